tlul_reg_bridge: RTL and testbench
==================================

// Module: tlul_reg_bridge
// PURPOSE
// - TL-UL device adapter sitting directly upstream of the PWM/timer register file.
// - Converts one TL-UL A-channel request into a single-cycle re_o/we_o register access.
// - Returns the matching D-channel response one cycle later, with one transaction outstanding.
// - Detects illegal requests and answers them with an error response, without touching the registers.
// PARAMETERS
// - ADDR_W     8          width of the register-side address (byte address).
// - SRC_W      8          width of the TL-UL source ID.
// - BASE_ADDR  32'h0      device window base; bits [31:ADDR_W] are compared, lower bits are ignored.
// - FLOW_THRU  1          1: accept a new A in the same cycle the D response is accepted; 0: idle cycle required.
// PORTS
// - clk_i           in   1       system clock.
// - rst_ni          in   1       asynchronous, active-low reset.
// - tl_a_valid_i    in   1       A-channel request valid.
// - tl_a_opcode_i   in   3       0=PutFullData, 1=PutPartialData, 4=Get.
// - tl_a_size_i     in   2       log2 of bytes; only 2 (32-bit) is legal.
// - tl_a_source_i   in   SRC_W   request ID, echoed on D.
// - tl_a_address_i  in   32      byte address.
// - tl_a_mask_i     in   4       byte lanes.
// - tl_a_data_i     in   32      write data.
// - tl_a_ready_o    out  1       A accepted when valid & ready.
// - tl_d_valid_o    out  1       response valid.
// - tl_d_opcode_o   out  3       0=AccessAck (writes), 1=AccessAckData (Get).
// - tl_d_size_o     out  2       echoes request size.
// - tl_d_source_o   out  SRC_W   echoes request source.
// - tl_d_data_o     out  32      read data; 0 for writes and errors.
// - tl_d_error_o    out  1       1 for an illegal request.
// - tl_d_ready_i    in   1       host accepts response.
// - re_o / we_o     out  1       register read / write strobe, 1-cycle pulse, mutually exclusive.
// - addr_o          out  ADDR_W  tl_a_address_i[ADDR_W-1:0].
// - wdata_o / be_o  out  32 / 4  tl_a_data_i / tl_a_mask_i passthrough.
// - rdata_i         in   32      register read data, combinational from addr_o.
// BEHAVIOUR
// - FSM has two states: IDLE and RESP.
//   - tl_a_ready_o = (IDLE) | (RESP & tl_d_ready_i & FLOW_THRU).
//   - Handshake (A valid & ready):
//     - legal request: re_o or we_o is driven in that same cycle (combinational).
//     - rdata_i, source and size are registered into the D holding register on that edge.
//     - next state is RESP.
//   - In RESP, tl_d_valid_o=1 and all D fields are held stable until tl_d_ready_i.
//     - D accepted with no new A: next state is IDLE.
//     - D accepted with a simultaneous new A (FLOW_THRU=1): stay in RESP and load the new response; no bubble.
// - Latency: A handshake to D valid is exactly 1 cycle.
// - Back-to-back sustained throughput: 1 transaction/cycle if FLOW_THRU=1, otherwise 1 per 2 cycles.
// - Error conditions (any one sets tl_d_error_o=1, suppresses re_o/we_o, sets data=0):
//   - opcode not in {0,1,4};
//   - size!=2;
//   - address[1:0]!=0;
//   - address[31:ADDR_W]!=BASE_ADDR[31:ADDR_W];
//   - PutFullData with mask!=4'hF;
//   - PutPartialData with mask==0.
// - Error response opcode:
//   - Get: AccessAckData;
//   - Put*: AccessAck;
//   - illegal opcode: AccessAck.
// - Get mask is ignored for data: the full 32-bit rdata_i is returned.
// - re_o and we_o are never 1 outside an A handshake cycle and never 1 together.
// - Reset (asynchronous, any state):
//   - state goes to IDLE;
//   - tl_d_valid_o=0, tl_d_error_o=0, D data/source/size/opcode=0;
//   - tl_a_ready_o=1 after release;
//   - a response in flight is dropped.
// - All D outputs come from registers; only tl_a_ready_o, re_o, we_o, addr_o, wdata_o and be_o are combinational.
// STRUCTURE
// - tlul_pkg:
//   - opcode localparams (PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACK=0, ACK_DATA=1);
//   - tl_a/tl_d field widths;
//   - state enum {IDLE, RESP}.
// - One sub-module, tlul_err_check: purely combinational legality check on the A fields; outputs err and is_read.
// - Top level holds the FSM, the D holding register and the strobe generation.
// TESTING
// - Get 0x08 with rdata_i=32'h1234 at the handshake:
//   - re_o pulses 1 cycle;
//   - next cycle D is valid with opcode=1, data=0x1234, error=0, source echoed.
// - PutFull 0x0C, data 0x00FF, mask F:
//   - we_o pulses with addr_o=0x0C, be_o=F;
//   - D is AccessAck with error=0.
// - Illegal requests (PutFull with mask 4'h3; Get at 0x102 with BASE 0; opcode 2; size 1):
//   - no re_o/we_o;
//   - D has error=1, data=0.
// - Hold tl_d_ready_i=0 for 5 cycles:
//   - D fields stay stable;
//   - tl_a_ready_o=0;
//   - a second A is not accepted and no strobe occurs.
// - FLOW_THRU=1 with 4 back-to-back Gets and d_ready=1: 4 responses on consecutive cycles, in order; FLOW_THRU=0 gives 2-cycle spacing.
// - Assert rst_ni low while in RESP: d_valid drops immediately; after release, a new Get completes normally.

Source files
------------

// File: rtl/tlul_pkg.sv
// Shared TL-UL field widths, opcode encodings and bridge FSM state type.
package tlul_pkg;

    localparam int TL_AW   = 32;
    localparam int TL_DW   = 32;
    localparam int TL_MW   = 4;
    localparam int TL_SZW  = 2;
    localparam int TL_OPW  = 3;

    localparam logic [TL_OPW-1:0] PUT_FULL    = 3'd0;
    localparam logic [TL_OPW-1:0] PUT_PARTIAL = 3'd1;
    localparam logic [TL_OPW-1:0] GET         = 3'd4;
    localparam logic [TL_OPW-1:0] ACK         = 3'd0;
    localparam logic [TL_OPW-1:0] ACK_DATA    = 3'd1;

    localparam logic [TL_SZW-1:0] SIZE_WORD   = 2'd2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/tlul_err_check.sv
// Combinational legality check of a TL-UL A-channel request against this
// device: opcode, size, alignment, address window and write mask.
module tlul_err_check
    import tlul_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic [TL_OPW-1:0]   opcode_i,
    input  logic [TL_SZW-1:0]   size_i,
    input  logic [31-ADDR_W:0]  addr_hi_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [TL_MW-1:0]    mask_i,
    output logic                err_o,
    output logic                is_read_o
);

    logic op_bad_s;
    logic mask_bad_s;
    logic size_bad_s;
    logic align_bad_s;
    logic window_bad_s;

    // Decode opcode and the opcode-dependent mask rule.
    always_comb begin
        op_bad_s   = 1'b0;
        mask_bad_s = 1'b0;
        is_read_o  = 1'b0;
        case (opcode_i)
            PUT_FULL:    mask_bad_s = (mask_i != 4'hF);
            PUT_PARTIAL: mask_bad_s = (mask_i == 4'h0);
            GET:         is_read_o  = 1'b1;
            default:     op_bad_s   = 1'b1;
        endcase
    end

    assign size_bad_s   = (size_i != SIZE_WORD);
    assign align_bad_s  = (addr_lo_i != 2'b00);
    assign window_bad_s = (addr_hi_i != BASE_ADDR[31:ADDR_W]);

    assign err_o = op_bad_s | mask_bad_s | size_bad_s | align_bad_s | window_bad_s;

endmodule

// File: rtl/tlul_reg_bridge.sv
// TL-UL device adapter: one A request becomes a single-cycle register strobe,
// answered from a registered D holding stage one cycle later.
module tlul_reg_bridge
    import tlul_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          SRC_W     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter bit          FLOW_THRU = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tl_a_valid_i,
    input  logic [TL_OPW-1:0]   tl_a_opcode_i,
    input  logic [TL_SZW-1:0]   tl_a_size_i,
    input  logic [SRC_W-1:0]    tl_a_source_i,
    input  logic [TL_AW-1:0]    tl_a_address_i,
    input  logic [TL_MW-1:0]    tl_a_mask_i,
    input  logic [TL_DW-1:0]    tl_a_data_i,
    output logic                tl_a_ready_o,
    output logic                tl_d_valid_o,
    output logic [TL_OPW-1:0]   tl_d_opcode_o,
    output logic [TL_SZW-1:0]   tl_d_size_o,
    output logic [SRC_W-1:0]    tl_d_source_o,
    output logic [TL_DW-1:0]    tl_d_data_o,
    output logic                tl_d_error_o,
    input  logic                tl_d_ready_i,
    output logic                re_o,
    output logic                we_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [TL_DW-1:0]    wdata_o,
    output logic [TL_MW-1:0]    be_o,
    input  logic [TL_DW-1:0]    rdata_i
);

    state_e              state_q, state_d;
    logic                d_valid_q, d_valid_d;
    logic [TL_OPW-1:0]   d_opcode_q, d_opcode_d;
    logic [TL_SZW-1:0]   d_size_q, d_size_d;
    logic [SRC_W-1:0]    d_source_q, d_source_d;
    logic [TL_DW-1:0]    d_data_q, d_data_d;
    logic                d_error_q, d_error_d;

    logic                err_s;
    logic                is_read_s;
    logic                a_ready_s;
    logic                a_hs_s;
    logic                re_s;
    logic                we_s;

    tlul_err_check #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_err_check (
        .opcode_i  (tl_a_opcode_i),
        .size_i    (tl_a_size_i),
        .addr_hi_i (tl_a_address_i[31:ADDR_W]),
        .addr_lo_i (tl_a_address_i[1:0]),
        .mask_i    (tl_a_mask_i),
        .err_o     (err_s),
        .is_read_o (is_read_s)
    );

    // Next-state, D holding register load and register strobe generation.
    always_comb begin
        state_d    = state_q;
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_data_d   = d_data_q;
        d_error_d  = d_error_q;
        a_ready_s  = 1'b0;
        re_s       = 1'b0;
        we_s       = 1'b0;

        case (state_q)
            IDLE:    a_ready_s = 1'b1;
            RESP:    a_ready_s = tl_d_ready_i & FLOW_THRU;
            default: a_ready_s = 1'b0;
        endcase

        a_hs_s = tl_a_valid_i & a_ready_s;

        if (a_hs_s) begin
            // A new handshake always wins: it either starts or replaces the response.
            state_d    = RESP;
            d_valid_d  = 1'b1;
            d_opcode_d = is_read_s ? ACK_DATA : ACK;
            d_size_d   = tl_a_size_i;
            d_source_d = tl_a_source_i;
            d_error_d  = err_s;
            d_data_d   = (is_read_s && !err_s) ? rdata_i : 32'h0;
            if (err_s) begin
                re_s = 1'b0;
                we_s = 1'b0;
            end else if (is_read_s) begin
                re_s = 1'b1;
            end else begin
                we_s = 1'b1;
            end
        end else if ((state_q == RESP) && tl_d_ready_i) begin
            state_d   = IDLE;
            d_valid_d = 1'b0;
        end else begin
            state_d = state_q;
        end
    end

    // State and D holding registers; reset drops any response in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            d_valid_q  <= 1'b0;
            d_opcode_q <= 3'd0;
            d_size_q   <= 2'd0;
            d_source_q <= {SRC_W{1'b0}};
            d_data_q   <= 32'h0;
            d_error_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_data_q   <= d_data_d;
            d_error_q  <= d_error_d;
        end
    end

    assign tl_a_ready_o  = a_ready_s;
    assign tl_d_valid_o  = d_valid_q;
    assign tl_d_opcode_o = d_opcode_q;
    assign tl_d_size_o   = d_size_q;
    assign tl_d_source_o = d_source_q;
    assign tl_d_data_o   = d_data_q;
    assign tl_d_error_o  = d_error_q;
    assign re_o          = re_s;
    assign we_o          = we_s;
    assign addr_o        = tl_a_address_i[ADDR_W-1:0];
    assign wdata_o       = tl_a_data_i;
    assign be_o          = tl_a_mask_i;

endmodule

// File: tb/tb_tlul_reg_bridge.sv
// Directed bench for tlul_reg_bridge: one flow-through instance for the main
// checks and one FLOW_THRU=0 instance for back-to-back spacing.
module tb_tlul_reg_bridge;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
    logic [31:0] rdata;

    logic        a_ready, d_valid, d_error, re, we;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [7:0]  d_source, addr;
    logic [31:0] d_data, wdata;
    logic [3:0]  be;

    logic        nf_a_valid;
    logic        nf_d_ready;
    logic        nf_a_ready, nf_d_valid, nf_d_error, nf_re, nf_we;
    logic [2:0]  nf_d_opcode;
    logic [1:0]  nf_d_size;
    logic [7:0]  nf_d_source, nf_addr;
    logic [31:0] nf_d_data, nf_wdata;
    logic [3:0]  nf_be;

    int n_checks = 0;
    int n_errors = 0;

    tlul_reg_bridge #(.ADDR_W(8), .SRC_W(8), .BASE_ADDR(32'h0), .FLOW_THRU(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .tl_a_valid_i(a_valid), .tl_a_opcode_i(a_opcode), .tl_a_size_i(a_size),
        .tl_a_source_i(a_source), .tl_a_address_i(a_address), .tl_a_mask_i(a_mask),
        .tl_a_data_i(a_data), .tl_a_ready_o(a_ready),
        .tl_d_valid_o(d_valid), .tl_d_opcode_o(d_opcode), .tl_d_size_o(d_size),
        .tl_d_source_o(d_source), .tl_d_data_o(d_data), .tl_d_error_o(d_error),
        .tl_d_ready_i(d_ready), .re_o(re), .we_o(we), .addr_o(addr),
        .wdata_o(wdata), .be_o(be), .rdata_i(rdata)
    );

    tlul_reg_bridge #(.ADDR_W(8), .SRC_W(8), .BASE_ADDR(32'h0), .FLOW_THRU(1'b0)) dut_nf (
        .clk_i(clk), .rst_ni(rst_n),
        .tl_a_valid_i(nf_a_valid), .tl_a_opcode_i(a_opcode), .tl_a_size_i(a_size),
        .tl_a_source_i(a_source), .tl_a_address_i(a_address), .tl_a_mask_i(a_mask),
        .tl_a_data_i(a_data), .tl_a_ready_o(nf_a_ready),
        .tl_d_valid_o(nf_d_valid), .tl_d_opcode_o(nf_d_opcode), .tl_d_size_o(nf_d_size),
        .tl_d_source_o(nf_d_source), .tl_d_data_o(nf_d_data), .tl_d_error_o(nf_d_error),
        .tl_d_ready_i(nf_d_ready), .re_o(nf_re), .we_o(nf_we), .addr_o(nf_addr),
        .wdata_o(nf_wdata), .be_o(nf_be), .rdata_i(rdata)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one request, check strobes at handshake and D fields one cycle later.
    task automatic send(input string tag, input logic [2:0] op, input logic [1:0] sz,
                        input logic [31:0] ad, input logic [3:0] mk, input logic [31:0] wd,
                        input logic [31:0] rd, input logic [7:0] src,
                        input logic exp_re, input logic exp_we, input logic exp_err,
                        input logic [2:0] exp_op, input logic [31:0] exp_data);
        @(posedge clk); #1;
        a_opcode = op; a_size = sz; a_address = ad; a_mask = mk;
        a_data = wd; rdata = rd; a_source = src; a_valid = 1'b1;
        #1;
        check_eq({tag, ".a_ready"}, {31'h0, a_ready}, 32'h1);
        check_eq({tag, ".re"}, {31'h0, re}, {31'h0, exp_re});
        check_eq({tag, ".we"}, {31'h0, we}, {31'h0, exp_we});
        check_eq({tag, ".addr"}, {24'h0, addr}, {24'h0, ad[7:0]});
        check_eq({tag, ".be"}, {28'h0, be}, {28'h0, mk});
        check_eq({tag, ".wdata"}, wdata, wd);
        @(posedge clk); #1;
        a_valid = 1'b0; rdata = 32'hFFFF_FFFF;
        #1;
        check_eq({tag, ".d_valid"}, {31'h0, d_valid}, 32'h1);
        check_eq({tag, ".d_opcode"}, {29'h0, d_opcode}, {29'h0, exp_op});
        check_eq({tag, ".d_data"}, d_data, exp_data);
        check_eq({tag, ".d_error"}, {31'h0, d_error}, {31'h0, exp_err});
        check_eq({tag, ".d_source"}, {24'h0, d_source}, {24'h0, src});
        check_eq({tag, ".d_size"}, {30'h0, d_size}, {30'h0, sz});
        check_eq({tag, ".no_strobe"}, {30'h0, re, we}, 32'h0);
        @(posedge clk); #1;
        check_eq({tag, ".d_done"}, {31'h0, d_valid}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; nf_a_valid = 1'b0; d_ready = 1'b1; nf_d_ready = 1'b1;
        a_opcode = 3'd0; a_size = 2'd0; a_source = 8'h0; a_address = 32'h0;
        a_mask = 4'h0; a_data = 32'h0; rdata = 32'h0;
        #12;
        check_eq("rst.d_valid", {31'h0, d_valid}, 32'h0);
        check_eq("rst.d_error", {31'h0, d_error}, 32'h0);
        check_eq("rst.d_data", d_data, 32'h0);
        check_eq("rst.d_fields", {19'h0, d_opcode, d_size, d_source}, 32'h0);
        rst_n = 1'b1;
        #1;
        check_eq("rst.a_ready", {31'h0, a_ready}, 32'h1);

        // tag op size addr mask wdata rdata src re we err d_op d_data
        send("get08",    3'd4, 2'd2, 32'h08,  4'hF, 32'h0,    32'h1234, 8'h5A, 1'b1, 1'b0, 1'b0, 3'd1, 32'h1234);
        send("putfull",  3'd0, 2'd2, 32'h0C,  4'hF, 32'h00FF, 32'hAAAA, 8'h11, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0);
        send("putpart",  3'd1, 2'd2, 32'h10,  4'h3, 32'h5678, 32'hAAAA, 8'h12, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0);
        send("get_msk0", 3'd4, 2'd2, 32'h24,  4'h0, 32'h0,    32'h9ABC, 8'h13, 1'b1, 1'b0, 1'b0, 3'd1, 32'h9ABC);
        send("e_fullmk", 3'd0, 2'd2, 32'h0C,  4'h3, 32'h00FF, 32'hDEAD, 8'h21, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        send("e_window", 3'd4, 2'd2, 32'h102, 4'hF, 32'h0,    32'hDEAD, 8'h22, 1'b0, 1'b0, 1'b1, 3'd1, 32'h0);
        send("e_op2",    3'd2, 2'd2, 32'h08,  4'hF, 32'h0,    32'hDEAD, 8'h23, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        send("e_size1",  3'd4, 2'd1, 32'h04,  4'hF, 32'h0,    32'hDEAD, 8'h24, 1'b0, 1'b0, 1'b1, 3'd1, 32'h0);
        send("e_align",  3'd4, 2'd2, 32'h06,  4'hF, 32'h0,    32'hDEAD, 8'h25, 1'b0, 1'b0, 1'b1, 3'd1, 32'h0);
        send("e_partm0", 3'd1, 2'd2, 32'h10,  4'h0, 32'h1,    32'hDEAD, 8'h26, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0);

        // Backpressure: D held for 5 cycles while a second Get waits.
        @(posedge clk); #1;
        d_ready = 1'b0; a_opcode = 3'd4; a_size = 2'd2; a_address = 32'h14;
        a_mask = 4'hF; rdata = 32'hCAFE; a_source = 8'h33; a_valid = 1'b1;
        @(posedge clk); #1;
        a_address = 32'h18; rdata = 32'hBEEF; a_source = 8'h34;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("stall.d_valid", {31'h0, d_valid}, 32'h1);
            check_eq("stall.d_data", d_data, 32'hCAFE);
            check_eq("stall.d_source", {24'h0, d_source}, 32'h33);
            check_eq("stall.a_ready", {31'h0, a_ready}, 32'h0);
            check_eq("stall.strobe", {30'h0, re, we}, 32'h0);
            @(posedge clk); #1;
        end
        d_ready = 1'b1;
        #1;
        check_eq("stall.release_ready", {31'h0, a_ready}, 32'h1);
        check_eq("stall.release_re", {31'h0, re}, 32'h1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        #1;
        check_eq("stall.second_data", d_data, 32'hBEEF);
        check_eq("stall.second_src", {24'h0, d_source}, 32'h34);
        @(posedge clk); #1;
        check_eq("stall.done", {31'h0, d_valid}, 32'h0);

        // Flow-through: 4 back-to-back Gets, one response per cycle.
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k > 0) begin
                check_eq("b2b.d_valid", {31'h0, d_valid}, 32'h1);
                check_eq("b2b.d_data", d_data, 32'h100 + k - 1);
                check_eq("b2b.d_source", {24'h0, d_source}, k - 1);
            end
            if (k < 4) begin
                a_valid = 1'b1; a_opcode = 3'd4; a_size = 2'd2; a_mask = 4'hF;
                a_address = 32'(4 * k); rdata = 32'h100 + k; a_source = 8'(k);
                #1;
                check_eq("b2b.re", {31'h0, re}, 32'h1);
            end else begin
                a_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        check_eq("b2b.done", {31'h0, d_valid}, 32'h0);

        // No flow-through: continuous valid gives a response every other cycle.
        a_opcode = 3'd4; a_size = 2'd2; a_address = 32'h1C; a_mask = 4'hF; rdata = 32'h77;
        nf_a_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check_eq("nf.d_valid", {31'h0, nf_d_valid}, {31'h0, i[0]});
            check_eq("nf.a_ready", {31'h0, nf_a_ready}, {31'h0, ~i[0]});
        end
        nf_a_valid = 1'b0;

        // Reset while a response is pending.
        @(posedge clk); #1;
        d_ready = 1'b0; a_valid = 1'b1; a_address = 32'h20; rdata = 32'h77; a_source = 8'h44;
        @(posedge clk); #1;
        a_valid = 1'b0;
        check_eq("rstresp.pre_valid", {31'h0, d_valid}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rstresp.d_valid", {31'h0, d_valid}, 32'h0);
        check_eq("rstresp.d_data", d_data, 32'h0);
        check_eq("rstresp.d_fields", {19'h0, d_opcode, d_size, d_source}, 32'h0);
        #2 rst_n = 1'b1; d_ready = 1'b1;
        send("get_after_rst", 3'd4, 2'd2, 32'h08, 4'hF, 32'h0, 32'h4321, 8'h66,
             1'b1, 1'b0, 1'b0, 3'd1, 32'h4321);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
